// File: rtl/controller_pkg.sv
// Shared decode definitions for the instruction controller: opcode encodings,
// instruction field positions and the decoded control bundle.
package controller_pkg;

   typedef enum logic [3:0] {
      OP_ALUR  = 4'h0,
      OP_CMPR  = 4'h2,
      OP_SW    = 4'h5,
      OP_BCOND = 4'h6,
      OP_ALUI  = 4'h8,
      OP_LW    = 4'h9,
      OP_CMPI  = 4'hA,
      OP_JAL   = 4'hB
   } op1_e;

   localparam int DATA_W  = 32;
   localparam int IMM_W   = 16;
   localparam int SEL_W   = 4;
   localparam int OP1_LSB = 0;
   localparam int FN_LSB  = 4;
   localparam int IMM_LSB = 8;
   localparam int RS2_LSB = 20;
   localparam int RS1_LSB = 24;
   localparam int RD_LSB  = 28;

   localparam int              CMP_BIT       = 4;
   localparam logic [4:0]      ALUOP_ADD     = 5'h00;
   localparam logic [4:0]      ALUOP_CMP_CLS = 5'(1) << CMP_BIT;
   localparam logic [DATA_W-1:0] PC_STEP     = 32'd4;

   typedef struct packed {
      logic [SEL_W-1:0]         selRegRead1;
      logic [SEL_W-1:0]         selRegRead2;
      logic [SEL_W-1:0]         selRegWrite;
      logic signed [DATA_W-1:0] imm;
      logic [4:0]               selALUop;
      logic                     enBranch;
      logic                     enRegWrite;
      logic                     enMemWrite;
      logic                     aluSrcIsReg;
      logic                     memToReg;
   } ctrl_t;

   function automatic logic signed [DATA_W-1:0] signExt16(input logic [IMM_W-1:0] v);
      return {{(DATA_W-IMM_W){v[IMM_W-1]}}, v};
   endfunction

endpackage

// File: rtl/controller_decode.sv
// Pure combinational instruction decode: splits the word into fields and
// produces register selects, immediate, ALU op and enables per opcode.
module controller_decode
   import controller_pkg::*;
(
   input  logic [DATA_W-1:0] instWord,
   output ctrl_t             ctrl
);

   logic [3:0]       op1;
   logic [3:0]       fn;
   logic [SEL_W-1:0] rs1;
   logic [SEL_W-1:0] rs2;
   logic [SEL_W-1:0] rd;

   assign op1 = instWord[OP1_LSB +: 4];
   assign fn  = instWord[FN_LSB  +: 4];
   assign rs1 = instWord[RS1_LSB +: SEL_W];
   assign rs2 = instWord[RS2_LSB +: SEL_W];
   assign rd  = instWord[RD_LSB  +: SEL_W];

   always_comb begin
      ctrl     = '0;
      // The immediate is produced for every opcode, including illegal ones.
      ctrl.imm = signExt16(instWord[IMM_LSB +: IMM_W]);
      case (op1)
         OP_ALUR, OP_CMPR: begin
            ctrl.selRegRead1 = rs1;
            ctrl.selRegRead2 = rs2;
            ctrl.selRegWrite = rd;
            ctrl.selALUop    = (op1 == OP_CMPR) ? (ALUOP_CMP_CLS | {1'b0, fn}) : {1'b0, fn};
            ctrl.aluSrcIsReg = 1'b1;
            ctrl.enRegWrite  = 1'b1;
         end
         OP_ALUI, OP_CMPI: begin
            ctrl.selRegRead1 = rs1;
            ctrl.selRegWrite = rd;
            ctrl.selALUop    = (op1 == OP_CMPI) ? (ALUOP_CMP_CLS | {1'b0, fn}) : {1'b0, fn};
            ctrl.enRegWrite  = 1'b1;
         end
         OP_LW: begin
            ctrl.selRegRead1 = rs1;
            ctrl.selRegWrite = rd;
            ctrl.selALUop    = ALUOP_ADD;
            ctrl.enRegWrite  = 1'b1;
            ctrl.memToReg    = 1'b1;
         end
         OP_SW: begin
            ctrl.selRegRead1 = rs1;
            ctrl.selRegRead2 = rd;
            ctrl.selALUop    = ALUOP_ADD;
            ctrl.enMemWrite  = 1'b1;
         end
         OP_BCOND: begin
            // rd is read, not written: it is the second compare operand.
            ctrl.selRegRead1 = rs1;
            ctrl.selRegRead2 = rd;
            ctrl.selALUop    = ALUOP_CMP_CLS | {1'b0, fn};
            ctrl.aluSrcIsReg = 1'b1;
            ctrl.enBranch    = 1'b1;
         end
         OP_JAL: begin
            ctrl.selRegRead1 = rs1;
            ctrl.selRegWrite = rd;
            ctrl.selALUop    = ALUOP_ADD;
            ctrl.enRegWrite  = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/controller.sv
// Instruction controller: decode, next-PC candidate and optional output register.
// Define CONTROLLER_OUTREG_EN to register all outputs (1-cycle latency).
module controller
   import controller_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] pcOut,
   input  logic [DATA_W-1:0] instWord,
   output logic [SEL_W-1:0]  selRegRead1,
   output logic [SEL_W-1:0]  selRegRead2,
   output logic [SEL_W-1:0]  selRegWrite,
   output logic [DATA_W-1:0] imm,
   output logic [4:0]        selALUop,
   output logic [DATA_W-1:0] pcNext,
   output logic              enBranch,
   output logic              enRegWrite,
   output logic              enMemWrite,
   output logic              aluSrcIsReg,
   output logic              memToReg
);

   ctrl_t             ctrl_p0;
   logic [DATA_W-1:0] pcPlus4_p0;
   logic [DATA_W-1:0] pcNext_p0;
   ctrl_t             ctrlOut;
   logic [DATA_W-1:0] pcNextOut;

   controller_decode uDecode (
      .instWord (instWord),
      .ctrl     (ctrl_p0)
   );

   // Word offset added as raw bits so any overflow wraps modulo 2^32.
   assign pcPlus4_p0 = pcOut + PC_STEP;
   assign pcNext_p0  = ctrl_p0.enBranch ? (pcPlus4_p0 + {ctrl_p0.imm[DATA_W-3:0], 2'b00})
                                        : pcPlus4_p0;

`ifdef CONTROLLER_OUTREG_EN
   ctrl_t             ctrl_p1;
   logic [DATA_W-1:0] pcNext_p1;

   // ---- stage p0 -> p1: output register ----
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ctrl_p1   <= '0;
         pcNext_p1 <= '0;
      end else begin
         ctrl_p1   <= ctrl_p0;
         pcNext_p1 <= pcNext_p0;
      end
   end

   assign ctrlOut   = ctrl_p1;
   assign pcNextOut = pcNext_p1;
`else
   logic unusedClkReset;
   assign unusedClkReset = clk ^ reset;

   assign ctrlOut   = ctrl_p0;
   assign pcNextOut = pcNext_p0;
`endif

   assign selRegRead1 = ctrlOut.selRegRead1;
   assign selRegRead2 = ctrlOut.selRegRead2;
   assign selRegWrite = ctrlOut.selRegWrite;
   assign imm         = ctrlOut.imm;
   assign selALUop    = ctrlOut.selALUop;
   assign pcNext      = pcNextOut;
   assign enBranch    = ctrlOut.enBranch;
   assign enRegWrite  = ctrlOut.enRegWrite;
   assign enMemWrite  = ctrlOut.enMemWrite;
   assign aluSrcIsReg = ctrlOut.aluSrcIsReg;
   assign memToReg    = ctrlOut.memToReg;

endmodule

// File: tb/tb_controller.sv
// Self-checking bench for controller: directed vectors, random instructions
// against a behavioural decode model, and reset behaviour.
module tb_controller;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] pcOut;
   logic [31:0] instWord;
   logic [3:0]  selRegRead1, selRegRead2, selRegWrite;
   logic [31:0] imm;
   logic [4:0]  selALUop;
   logic [31:0] pcNext;
   logic        enBranch, enRegWrite, enMemWrite, aluSrcIsReg, memToReg;

   int nCompared   = 0;
   int nMismatched = 0;

   typedef struct packed {
      logic [3:0]  s1, s2, sw;
      logic [31:0] imm;
      logic [4:0]  op;
      logic [31:0] pcn;
      logic        br, rw, mw, src, m2r;
   } exp_t;

   exp_t prevExp;

   always #5 clk = ~clk;

   controller dut (
      .clk         (clk),
      .reset       (reset),
      .pcOut       (pcOut),
      .instWord    (instWord),
      .selRegRead1 (selRegRead1),
      .selRegRead2 (selRegRead2),
      .selRegWrite (selRegWrite),
      .imm         (imm),
      .selALUop    (selALUop),
      .pcNext      (pcNext),
      .enBranch    (enBranch),
      .enRegWrite  (enRegWrite),
      .enMemWrite  (enMemWrite),
      .aluSrcIsReg (aluSrcIsReg),
      .memToReg    (memToReg)
   );

   task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nCompared++;
      if (got !== exp) begin
         nMismatched++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Behavioural model: field arithmetic plus a per-opcode role table.
   function automatic exp_t model(input logic [31:0] pc, input logic [31:0] inst);
      exp_t e;
      int unsigned op1, fn, rs1, rs2, rd;
      shortint     imm16;
      op1   = inst % 16;
      fn    = (inst / 16) % 16;
      rs2   = (inst / (1 << 20)) % 16;
      rs1   = (inst / (1 << 24)) % 16;
      rd    = inst / (1 << 28);
      imm16 = shortint'((inst / 256) % 65536);
      e     = '0;
      e.imm = 32'(int'(imm16));
      e.pcn = pc + 32'd4 + ((op1 == 6) ? 32'(int'(imm16) * 4) : 32'd0);
      case (op1)
         0, 2: begin
            e.s1 = 4'(rs1); e.s2 = 4'(rs2); e.sw = 4'(rd);
            e.op = 5'(fn + ((op1 == 2) ? 16 : 0)); e.src = 1; e.rw = 1;
         end
         8, 10: begin
            e.s1 = 4'(rs1); e.sw = 4'(rd);
            e.op = 5'(fn + ((op1 == 10) ? 16 : 0)); e.rw = 1;
         end
         9:  begin e.s1 = 4'(rs1); e.sw = 4'(rd); e.rw = 1; e.m2r = 1; end
         5:  begin e.s1 = 4'(rs1); e.s2 = 4'(rd); e.mw = 1; end
         6:  begin e.s1 = 4'(rs1); e.s2 = 4'(rd); e.op = 5'(fn + 16); e.src = 1; e.br = 1; end
         11: begin e.s1 = 4'(rs1); e.sw = 4'(rd); e.rw = 1; end
         default: ;
      endcase
      return e;
   endfunction

   task automatic checkAll(input string tag, input exp_t e);
      checkEq({tag, ".sel1"}, 32'(selRegRead1), 32'(e.s1));
      checkEq({tag, ".sel2"}, 32'(selRegRead2), 32'(e.s2));
      checkEq({tag, ".selW"}, 32'(selRegWrite), 32'(e.sw));
      checkEq({tag, ".imm"}, imm, e.imm);
      checkEq({tag, ".aluOp"}, 32'(selALUop), 32'(e.op));
      checkEq({tag, ".pcNext"}, pcNext, e.pcn);
      checkEq({tag, ".enBranch"}, 32'(enBranch), 32'(e.br));
      checkEq({tag, ".enRegWrite"}, 32'(enRegWrite), 32'(e.rw));
      checkEq({tag, ".enMemWrite"}, 32'(enMemWrite), 32'(e.mw));
      checkEq({tag, ".aluSrcIsReg"}, 32'(aluSrcIsReg), 32'(e.src));
      checkEq({tag, ".memToReg"}, 32'(memToReg), 32'(e.m2r));
   endtask

   // Drive one instruction at negedge; outputs are checked after the next posedge.
   task automatic applyVec(input string tag, input logic [31:0] pc, input logic [31:0] inst);
      exp_t e;
      @(negedge clk);
      pcOut    = pc;
      instWord = inst;
      e        = model(pc, inst);
`ifdef CONTROLLER_OUTREG_EN
      #1;
      checkAll({tag, ".hold"}, prevExp);
`endif
      @(posedge clk);
      #1;
      checkAll(tag, e);
      prevExp = e;
   endtask

   task automatic resetPulse(input string tag);
      exp_t e;
      @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
`ifdef CONTROLLER_OUTREG_EN
      e = '0;
`else
      e = model(pcOut, instWord);
`endif
      checkAll(tag, e);
      @(negedge clk);
      reset   = 1'b0;
      prevExp = e;
   endtask

   localparam logic [3:0] LEGAL_OPS [8] = '{4'h0, 4'h2, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB};

   initial begin
      exp_t e0;
      reset    = 1'b1;
      pcOut    = 32'h0000_0100;
      instWord = 32'h1230_0000;
      #3;
`ifdef CONTROLLER_OUTREG_EN
      e0 = '0;
`else
      e0 = model(pcOut, instWord);
`endif
      checkAll("reset", e0);
      prevExp = e0;
      @(negedge clk);
      reset = 1'b0;

      applyVec("aluiNeg",   32'h0000_0040, 32'hC0F0_00B8);
      applyVec("alurFn0",   32'h0000_0000, 32'h0000_0000);
      applyVec("lw",        32'h0000_1000, 32'h0000_0009);
      applyVec("sw",        32'h0000_1004, 32'h0000_0005);
      applyVec("bcondM1",   32'h0000_0040, 32'h00FF_FF06);
      applyVec("illegal",   32'h0000_0050, 32'h0000_0003);
      applyVec("jal",       32'h0000_0200, 32'h7A12_34FB);
      applyVec("bcondWrap", 32'hFFFF_FFF0, 32'h5A7F_FF36);
      applyVec("pcWrap",    32'hFFFF_FFFC, 32'hFFFF_FFFA);
      applyVec("cmpr",      32'h0000_0300, 32'h3456_78F2);
      resetPulse("resetMid");
      applyVec("afterReset", 32'h0000_0400, 32'h9876_5420);

      for (int i = 0; i < 300; i++) begin
         logic [31:0] inst;
         inst = $urandom;
         if ($urandom_range(9) < 8) inst[3:0] = LEGAL_OPS[$urandom_range(7)];
         applyVec("rand", $urandom, inst);
         if (i % 100 == 57) resetPulse("resetRand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish within budget");
      $fatal(1);
   end

endmodule
